// File: rtl/fft_spectrum_render.sv
// Pixel-clock reader for the FFT frame RAM: draws bin magnitudes as green bars with a
// decaying red peak-hold marker and a white baseline, 4-clock pipeline from sync to RGB.
module fft_spectrum_render #(
    parameter int unsigned COLOR_DEPTH = 8,
    parameter int unsigned X_BITS      = 10,
    parameter int unsigned Y_BITS      = 10,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned H_ACT       = 640,
    parameter int unsigned V_ACT       = 480,
    parameter int unsigned FFT_POINT   = 256,
    parameter int unsigned BIN_SHIFT   = 1,
    parameter int unsigned X_OFF       = 64,
    parameter int unsigned MAG_SHIFT   = 6,
    parameter int unsigned DECAY       = 2
) (
    input  logic                   pix_clk,
    input  logic                   rst,
    input  logic [X_BITS-1:0]      act_x,
    input  logic [Y_BITS-1:0]      act_y,
    input  logic                   vs_in,
    input  logic                   hs_in,
    input  logic                   de_in,
    output logic [ADDR_W-1:0]      ram_rd_addr,
    input  logic [31:0]            ram_rd_data,
    output logic                   vs_out,
    output logic                   hs_out,
    output logic                   de_out,
    output logic [COLOR_DEPTH-1:0] r_out,
    output logic [COLOR_DEPTH-1:0] g_out,
    output logic [COLOR_DEPTH-1:0] b_out
);

    localparam int unsigned BIN_W = $clog2(FFT_POINT);
    localparam int unsigned PK_W  = $clog2(V_ACT);
    localparam logic [X_BITS:0] WIN_LO = (X_BITS + 1)'(X_OFF);
    localparam logic [X_BITS:0] WIN_HI = (X_BITS + 1)'(X_OFF + (FFT_POINT << BIN_SHIFT));
    localparam logic [X_BITS:0] H_LIM  = (X_BITS + 1)'(H_ACT);
    localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(V_ACT - 1);
    localparam logic [X_BITS-1:0] SUB_MASK = X_BITS'((1 << BIN_SHIFT) - 1);

    typedef enum logic {StWaitVs, StRun} state_e;

    state_e state_q;
    logic   vs_prev_q;

    // Sync/enable delay lines
    logic [3:0] vs_q;
    logic [3:0] hs_q;
    logic [2:0] de_q;

    // S0 combinational decode
    logic [X_BITS:0]   x_ext;
    logic [X_BITS-1:0] x_rel;
    logic              win_s0;
    logic              first_s0;

    // Stage registers
    logic              win1_q, first1_q;
    logic [Y_BITS-1:0] y1_q;
    logic              win2_q, first2_q;
    logic [Y_BITS-1:0] y2_q;
    logic [BIN_W-1:0]  bin2_q;
    logic              win3_q;
    logic [Y_BITS-1:0] y3_q;
    logic [PK_W-1:0]   hgt3_q, pk3_q;
    logic [PK_W-1:0]   line0_q;

    // S3 combinational
    logic [16:0]       abs_re, abs_im, mag, mag_sh;
    logic [PK_W-1:0]   hgt_s3, peak_rd, pk_draw, pk_new;
    logic              pk_upd;
    logic [Y_BITS-1:0] rows3;

    logic [PK_W-1:0]   peak_mem [FFT_POINT];

    always_comb begin
        x_ext    = {1'b0, act_x};
        x_rel    = act_x - X_BITS'(X_OFF);
        win_s0   = de_in && (x_ext >= WIN_LO) && (x_ext < WIN_HI) && (x_ext < H_LIM);
        first_s0 = (x_rel & SUB_MASK) == '0;
    end

    always_comb begin
        abs_re  = ram_rd_data[31] ? ({1'b0, ~ram_rd_data[31:16]} + 17'd1)
                                  : {1'b0, ram_rd_data[31:16]};
        abs_im  = ram_rd_data[15] ? ({1'b0, ~ram_rd_data[15:0]} + 17'd1)
                                  : {1'b0, ram_rd_data[15:0]};
        mag     = abs_re + abs_im;
        mag_sh  = mag >> MAG_SHIFT;
        hgt_s3  = (mag_sh > 17'(V_ACT - 1)) ? PK_W'(V_ACT - 1) : mag_sh[PK_W-1:0];
        peak_rd = peak_mem[bin2_q];
        // Line 0 keeps drawing the pre-update peak for the later pixels of each bin
        pk_draw = ((y2_q == '0) && !first2_q) ? line0_q : peak_rd;
        pk_upd  = win2_q && first2_q && (y2_q == '0);
        if (hgt_s3 > peak_rd) begin
            pk_new = hgt_s3;
        end else if (peak_rd > PK_W'(DECAY)) begin
            pk_new = peak_rd - PK_W'(DECAY);
        end else begin
            pk_new = '0;
        end
        rows3 = Y_LAST - y3_q;
    end

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            state_q   <= StWaitVs;
            vs_prev_q <= 1'b0;
        end else begin
            vs_prev_q <= vs_in;
            if (state_q == StWaitVs && vs_in && !vs_prev_q) begin
                state_q <= StRun;
            end
        end
    end

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            vs_q        <= '0;
            hs_q        <= '0;
            de_q        <= '0;
            ram_rd_addr <= '0;
            win1_q      <= 1'b0;
            first1_q    <= 1'b0;
            y1_q        <= '0;
            win2_q      <= 1'b0;
            first2_q    <= 1'b0;
            y2_q        <= '0;
            bin2_q      <= '0;
            win3_q      <= 1'b0;
            y3_q        <= '0;
            hgt3_q      <= '0;
            pk3_q       <= '0;
            line0_q     <= '0;
        end else begin
            vs_q        <= {vs_q[2:0], vs_in};
            hs_q        <= {hs_q[2:0], hs_in};
            de_q        <= {de_q[1:0], de_in};
            ram_rd_addr <= win_s0 ? ADDR_W'(x_rel >> BIN_SHIFT) : '0;
            win1_q      <= win_s0;
            first1_q    <= first_s0;
            y1_q        <= act_y;
            win2_q      <= win1_q;
            first2_q    <= first1_q;
            y2_q        <= y1_q;
            bin2_q      <= ram_rd_addr[BIN_W-1:0];
            win3_q      <= win2_q;
            y3_q        <= y2_q;
            hgt3_q      <= hgt_s3;
            pk3_q       <= pk_draw;
            if (pk_upd) begin
                line0_q <= peak_rd;
            end
        end
    end

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FFT_POINT; i++) begin
                peak_mem[i] <= '0;
            end
        end else if (pk_upd) begin
            peak_mem[bin2_q] <= pk_new;
        end
    end

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            de_out <= 1'b0;
            r_out  <= '0;
            g_out  <= '0;
            b_out  <= '0;
        end else begin
            de_out <= de_q[2] && (state_q == StRun);
            r_out  <= '0;
            g_out  <= '0;
            b_out  <= '0;
            if (state_q == StRun && win3_q) begin
                if (y3_q == Y_LAST) begin
                    r_out <= '1;
                    g_out <= '1;
                    b_out <= '1;
                end else if (pk3_q != '0 && rows3 == Y_BITS'(pk3_q)) begin
                    r_out <= '1;
                end else if (rows3 < Y_BITS'(hgt3_q)) begin
                    g_out <= '1;
                end
            end
        end
    end

    assign vs_out = vs_q[3];
    assign hs_out = hs_q[3];

endmodule

// File: tb/tb_fft_spectrum_render.sv
// Directed-plus-random bench for fft_spectrum_render; a pixel-level reference model predicts
// every output 4 clocks after the inputs that produce it.
module tb_fft_spectrum_render;

    logic        pix_clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  act_x = '0;
    logic [9:0]  act_y = '0;
    logic        vs_in = 1'b0;
    logic        hs_in = 1'b0;
    logic        de_in = 1'b0;
    logic [9:0]  ram_rd_addr;
    logic [31:0] ram_rd_data = '0;
    logic        vs_out, hs_out, de_out;
    logic [7:0]  r_out, g_out, b_out;

    fft_spectrum_render dut (
        .pix_clk    (pix_clk),
        .rst        (rst),
        .act_x      (act_x),
        .act_y      (act_y),
        .vs_in      (vs_in),
        .hs_in      (hs_in),
        .de_in      (de_in),
        .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data),
        .vs_out     (vs_out),
        .hs_out     (hs_out),
        .de_out     (de_out),
        .r_out      (r_out),
        .g_out      (g_out),
        .b_out      (b_out)
    );

    always #5 pix_clk = ~pix_clk;

    // Frame RAM with one clock of read latency
    logic [31:0] ram [256];
    always @(posedge pix_clk) ram_rd_data <= ram[ram_rd_addr[7:0]];

    typedef struct packed {
        logic [23:0] rgb;
        logic        de;
        logic        vs;
        logic        hs;
    } exp_t;

    exp_t exp_q[$];
    int   peak_m [256];
    int   line0_m [256];
    bit   run_m;
    bit   vs_prev_m;
    int   prev_y_m;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            peak_m[i]  = 0;
            line0_m[i] = 0;
        end
        run_m     = 1'b0;
        vs_prev_m = 1'b0;
        prev_y_m  = 1;
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back('0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_rgb", {8'h0, r_out, g_out, b_out}, 32'h0);
        chk("rst_de", 32'(de_out), 32'h0);
        chk("rst_vs", 32'(vs_out), 32'h0);
        chk("rst_hs", 32'(hs_out), 32'h0);
        chk("rst_addr", 32'(ram_rd_addr), 32'h0);
        @(posedge pix_clk);
        @(posedge pix_clk);
        @(negedge pix_clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic step(input int x, input int y, input bit de, input bit vs, input bit hs);
        int win, bin, re, im, mag, hgt, pk, rows;
        logic signed [15:0] re16, im16;
        exp_t e, o;
        win = (de && x >= 64 && x < 576) ? 1 : 0;
        bin = (win != 0) ? (x - 64) / 2 : 0;
        if (vs && !vs_prev_m) run_m = 1'b1;
        vs_prev_m = vs;
        if (y == 0 && prev_y_m != 0) begin
            for (int i = 0; i < 256; i++) line0_m[i] = peak_m[i];
        end
        prev_y_m = y;
        re16 = ram[bin][31:16];
        im16 = ram[bin][15:0];
        re   = re16;
        im   = im16;
        mag  = (re < 0 ? -re : re) + (im < 0 ? -im : im);
        hgt  = mag / 64;
        if (hgt > 479) hgt = 479;
        pk = (y == 0) ? line0_m[bin] : peak_m[bin];
        if (win != 0 && y == 0 && ((x - 64) % 2) == 0) begin
            peak_m[bin] = (hgt > peak_m[bin]) ? hgt : (peak_m[bin] > 2 ? peak_m[bin] - 2 : 0);
        end
        rows  = 479 - y;
        e.rgb = 24'h0;
        if (win != 0 && run_m) begin
            if (y == 479) e.rgb = 24'hFFFFFF;
            else if (pk != 0 && rows == pk) e.rgb = 24'hFF0000;
            else if (rows < hgt) e.rgb = 24'h00FF00;
        end
        e.de = de && run_m;
        e.vs = vs;
        e.hs = hs;
        exp_q.push_back(e);
        act_x = 10'(x);
        act_y = 10'(y);
        de_in = de;
        vs_in = vs;
        hs_in = hs;
        @(posedge pix_clk);
        @(negedge pix_clk);
        o = exp_q.pop_front();
        chk("addr", 32'(ram_rd_addr), 32'(bin));
        chk("rgb", {8'h0, r_out, g_out, b_out}, 32'(o.rgb));
        chk("de_out", 32'(de_out), 32'(o.de));
        chk("vs_out", 32'(vs_out), 32'(o.vs));
        chk("hs_out", 32'(hs_out), 32'(o.hs));
    endtask

    task automatic line(input int y, input int x0, input int x1, input bit rand_de);
        bit de;
        for (int x = x0; x <= x1; x++) begin
            de = rand_de ? ($urandom_range(0, 7) != 0) : 1'b1;
            step(x, y, de, 1'b0, 1'b0);
        end
        step(0, y, 1'b0, 1'b0, 1'b1);
        step(0, y, 1'b0, 1'b0, 1'b1);
        step(0, y, 1'b0, 1'b0, 1'b0);
        step(0, y, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic vs_pulse();
        for (int i = 0; i < 4; i++) step(0, 479, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(0, 479, 1'b0, 1'b1, i == 1);
        for (int i = 0; i < 8; i++) step(0, 479, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fill_ram(input logic [31:0] w);
        for (int i = 0; i < 256; i++) ram[i] = w;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        logic [15:0] a, b;
        int y0, xs;
        fill_ram(32'h0);
        do_reset();
        for (int i = 0; i < 6; i++) step(0, 0, 1'b0, 1'b0, (i % 2) == 1);

        // Waiting for vs: RGB and de_out stay low while hs still propagates
        fill_ram(32'h0400_0000);
        line(470, 60, 72, 1'b0);
        for (int i = 0; i < 6; i++) step(0, 470, 1'b0, 1'b0, (i % 3) == 0);
        vs_pulse();

        // Height-16 bars, window edges and baseline
        for (int y = 460; y < 480; y++) line(y, 60, 68, 1'b0);
        line(470, 570, 580, 1'b0);
        line(479, 570, 580, 1'b0);

        // Full-scale magnitude clamps to the top line
        for (int i = 0; i < 5; i++) ram[i] = 32'h7FFF_8000;
        line(1, 60, 74, 1'b0);
        line(2, 60, 74, 1'b0);
        line(240, 60, 74, 1'b0);
        line(478, 60, 74, 1'b0);
        line(479, 60, 74, 1'b0);

        // Reset in the middle of a drawn line
        for (int x = 60; x < 70; x++) step(x, 470, 1'b1, 1'b0, 1'b0);
        do_reset();
        line(470, 60, 70, 1'b0);
        vs_pulse();
        line(470, 60, 70, 1'b0);

        // Peak hold and decay across frames
        do_reset();
        vs_pulse();
        fill_ram(32'h0400_0000);
        for (int f = 1; f <= 10; f++) begin
            if (f == 2) fill_ram(32'h0);
            line(0, 60, 140, 1'b0);
            line(463, 60, 80, 1'b0);
            line(465, 60, 80, 1'b0);
            line(467, 60, 80, 1'b0);
            line(477, 60, 80, 1'b0);
            vs_pulse();
        end

        // Random spectra with random de gaps on drawn lines
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 256; i++) begin
                a = 16'($urandom_range(0, 8000));
                b = 16'($urandom_range(0, 8000));
                if ($urandom_range(0, 1) == 1) a = -a;
                if ($urandom_range(0, 1) == 1) b = -b;
                if ($urandom_range(0, 15) == 0) a = 16'h8000;
                ram[i] = {a, b};
            end
            line(0, 60, 580, 1'b0);
            for (int k = 0; k < 4; k++) begin
                y0 = $urandom_range(1, 479);
                xs = $urandom_range(40, 540);
                line(y0, xs, xs + 60, 1'b1);
            end
            line(479, 560, 590, 1'b1);
            vs_pulse();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
